// File: rtl/serial_frame_pkg.sv
// Framing constants shared by the serial transmitter and the detector side.
// Both ends import this package so that the state codes and header bit always agree.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DEFAULT_DATA_W = 8;
  localparam logic HEADER_BIT     = 1'b1;

endpackage

// File: rtl/tx_shift_reg.sv
// Payload shifter: loads a word, shifts right once per data cycle, and keeps an even-parity accumulator.
// Zero latency from shift to lsb; there is no backpressure, because the owning FSM paces every shift.
module tx_shift_reg
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              shift,
  output logic              lsb,
  output logic              parity
);

  logic [DATA_W-1:0] sreg;
  logic              par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      par  <= 1'b0;
    end else if (load) begin
      sreg <= data_in;
      par  <= 1'b0;
    end else if (shift) begin
      // Parity tracks exactly the bits that have been shifted onto the line.
      sreg <= sreg >> 1;
      par  <= par ^ sreg[0];
    end
  end

  assign lsb    = sreg[0];
  assign parity = par;

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serializer feeding the detector's I/S inputs; load -> header 1 cycle, first data bit 2 cycles.
// Loads that arrive while busy are dropped. Optional parity bit: SERIAL_FRAME_TX_PARITY_EN.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              I_out,
  output logic              S_out
);

  localparam int             CW   = $clog2(DATA_W);
  localparam logic [CW-1:0]  LAST = CW'(DATA_W - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, shift, lsb, par_bit;
  logic          busy_nxt, done_nxt, i_nxt, s_nxt;

  assign accept = load && ((state == IDLE) || (state == STOP));
  // Shift on every edge that puts a data bit onto the line, so lsb always holds the bit that is due next.
  assign shift  = (state_nxt == DATA);

  tx_shift_reg #(.DATA_W(DATA_W)) u_sreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .data_in (data_in),
    .shift   (shift),
    .lsb     (lsb),
    .parity  (par_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (load) state_nxt = START;
      START:  state_nxt = DATA;
      DATA: begin
        if (cnt == LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: state_nxt = STOP;
      STOP:   state_nxt = load ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so no input reaches a pin combinationally.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    i_nxt    = 1'b0;
    s_nxt    = 1'b0;
    case (state_nxt)
      START: begin
        busy_nxt = 1'b1;
        s_nxt    = 1'b1;
        i_nxt    = HEADER_BIT;
      end
      DATA: begin
        busy_nxt = 1'b1;
        s_nxt    = 1'b1;
        i_nxt    = lsb;
      end
      PARITY: begin
        busy_nxt = 1'b1;
        s_nxt    = 1'b1;
        i_nxt    = par_bit;
      end
      STOP:    done_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      I_out <= 1'b0;
      S_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DATA) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      busy  <= busy_nxt;
      done  <= done_nxt;
      I_out <= i_nxt;
      S_out <= s_nxt;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx. It covers reset, single frames, back-to-back frames,
// loads ignored while busy, and a reset in the middle of a frame.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       load = 1'b0;
  logic       busy, done, I_out, S_out;

  int checks = 0;
  int errors = 0;

  serial_frame_tx #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .load    (load),
    .busy    (busy),
    .done    (done),
    .I_out   (I_out),
    .S_out   (S_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_I"}, I_out, 1'b0);
    chk({tag, "_S"}, S_out, 1'b0);
  endtask

  // The frame header must already be on the line when this is called.
  // At data index inj, an extra load of 8'hFF is pulsed, which the DUT must ignore.
  task automatic check_frame(input logic [7:0] d, input int inj);
    chk("hdr_I", I_out, 1'b1);
    chk("hdr_S", S_out, 1'b1);
    chk("hdr_busy", busy, 1'b1);
    chk("hdr_done", done, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == inj) begin
        load = 1'b1;
        data_in = 8'hFF;
      end
      tick();
      if (i == inj) load = 1'b0;
      chk($sformatf("data%0d_I", i), I_out, d[i]);
      chk($sformatf("data%0d_S", i), S_out, 1'b1);
      chk($sformatf("data%0d_busy", i), busy, 1'b1);
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    tick();
    chk("par_I", I_out, ^d);
    chk("par_S", S_out, 1'b1);
    chk("par_done", done, 1'b0);
`endif
    tick();
    chk("gap_S", S_out, 1'b0);
    chk("gap_I", I_out, 1'b0);
    chk("gap_done", done, 1'b1);
    chk("gap_busy", busy, 1'b0);
  endtask

  task automatic start_frame(input logic [7:0] d);
    data_in = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    // Reset held for three cycles, then five idle cycles with load low.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_idle("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("post_rst");
    end

    // Basic frame 8'hA5: the data bits go out LSB first as 1,0,1,0,0,1,0,1.
    start_frame(8'hA5);
    check_frame(8'hA5, -1);
    tick();
    chk_idle("a5_after");

    // 8'h07 has three ones, so its even-parity bit is 1.
    start_frame(8'h07);
    check_frame(8'h07, -1);
    tick();
    chk_idle("07_after");

    // Back-to-back frames: load stays high, leaving exactly one gap cycle between them.
    data_in = 8'h01;
    load = 1'b1;
    tick();
    data_in = 8'h80;
    check_frame(8'h01, -1);
    tick();
    load = 1'b0;
    check_frame(8'h80, -1);
    tick();
    chk_idle("b2b_after");

    // A load pulse during a frame must be ignored, and no extra frame may follow.
    start_frame(8'h00);
    check_frame(8'h00, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("ign_after");
    end

    // Reset during the fourth data bit: the outputs drop immediately and no done pulse appears.
    start_frame(8'hC3);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_I_bit3", I_out, 1'b0);
    chk("mid_S_bit3", S_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("in_rst");
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_idle("rst_release");
    end
    start_frame(8'h3C);
    check_frame(8'h3C, -1);
    tick();
    chk_idle("3c_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
